// File: rtl/toggle_meter.sv
// ==== toggle_meter : half-period meter for an asynchronous toggle input, with timeout (rev 1.0) ====
`default_nettype none

module toggle_meter #(
  parameter logic [25:0] CNT_MAX = 26'd24_999_999,
  parameter logic [25:0] TOL     = 26'd1_000,
  parameter logic [25:0] TIMEOUT = 26'd50_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        sig_in,
  output logic [25:0] period_cnt,
  output logic        period_vld,
  output logic        in_range,
  output logic        timeout,
  output logic [15:0] edge_cnt
);

  localparam logic [25:0] CNT_LAST = TIMEOUT - 26'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    TMO  = 2'd2
  } state_t;

  state_t      state;
  logic        s1;
  logic        s2;
  logic        prev;
  logic [25:0] cnt;
  logic        edge_det;
  logic [25:0] dev;
  logic        dev_ok;

  assign edge_det = s2 ^ prev;

  // Subtract the smaller from the larger so the distance never wraps.
  assign dev    = (cnt >= CNT_MAX) ? (cnt - CNT_MAX) : (CNT_MAX - cnt);
  assign dev_ok = (dev <= TOL);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      prev       <= 1'b0;
      cnt        <= '0;
      period_cnt <= '0;
      period_vld <= 1'b0;
      in_range   <= 1'b0;
      timeout    <= 1'b0;
      edge_cnt   <= '0;
      state      <= IDLE;
    end else begin
      s1         <= sig_in;
      s2         <= s1;
      prev       <= s2;
      period_vld <= 1'b0;

      if (edge_det) begin
        edge_cnt <= edge_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (edge_det) begin
            state <= MEAS;
            cnt   <= '0;
          end
        end
        MEAS: begin
          // An edge on the final count still wins over the timeout.
          if (edge_det) begin
            period_cnt <= cnt;
            period_vld <= 1'b1;
            in_range   <= dev_ok;
            cnt        <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= TMO;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + 26'd1;
          end
        end
        TMO: begin
          if (edge_det) begin
            state   <= MEAS;
            cnt     <= '0;
            timeout <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_toggle_meter.sv
// ==== tb_toggle_meter : scoreboard bench for toggle_meter (CNT_MAX=99, TOL=2, TIMEOUT=300) (rev 1.0) ====
`default_nettype none

module tb_toggle_meter;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        sig_in  = 1'b0;
  logic [25:0] period_cnt;
  logic        period_vld;
  logic        in_range;
  logic        timeout;
  logic [15:0] edge_cnt;

  typedef struct packed {
    logic [25:0] cnt;
    logic        rng;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  toggle_meter #(
    .CNT_MAX (26'd99),
    .TOL     (26'd2),
    .TIMEOUT (26'd300)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .sig_in     (sig_in),
    .period_cnt (period_cnt),
    .period_vld (period_vld),
    .in_range   (in_range),
    .timeout    (timeout),
    .edge_cnt   (edge_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period_cnt"}, 32'(period_cnt), 32'd0);
    check({tag, "_period_vld"}, 32'(period_vld), 32'd0);
    check({tag, "_in_range"},   32'(in_range),   32'd0);
    check({tag, "_timeout"},    32'(timeout),    32'd0);
    check({tag, "_edge_cnt"},   32'(edge_cnt),   32'd0);
  endtask

  // Flip sig_in n clock edges from now; optionally queue the capture it must produce.
  task automatic toggle_after(input int n, input bit cap, input logic [25:0] c, input logic r);
    exp_t e;
    repeat (n) @(posedge sys_clk);
    #1 sig_in = ~sig_in;
    if (cap) begin
      e.cnt = c;
      e.rng = r;
      sb.push_back(e);
    end
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (period_vld) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vld: got period_cnt %0d with no capture expected", period_cnt);
      end else begin
        e = sb.pop_front();
        check("cap_period_cnt", 32'(period_cnt), 32'(e.cnt));
        check("cap_in_range",   32'(in_range),   32'(e.rng));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_zero("reset");
    sys_rst = 1'b0;

    // Arm, then a steady 100-cycle half-period.
    toggle_after(10, 1'b0, 26'd0, 1'b0);
    for (int i = 0; i < 5; i++) toggle_after(100, 1'b1, 26'd99, 1'b1);

    // Tolerance boundaries on both sides of CNT_MAX.
    toggle_after(102, 1'b1, 26'd101, 1'b1);
    toggle_after(103, 1'b1, 26'd102, 1'b0);
    toggle_after(98,  1'b1, 26'd97,  1'b1);
    toggle_after(97,  1'b1, 26'd96,  1'b0);
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    check("edge_cnt_10", 32'(edge_cnt), 32'd10);
    check("timeout_meas", 32'(timeout), 32'd0);

    // Silence: timeout must rise after 300 idle cycles and hold.
    repeat (285) @(posedge sys_clk);
    @(negedge sys_clk);
    check("timeout_before", 32'(timeout), 32'd0);
    repeat (30) @(posedge sys_clk);
    @(negedge sys_clk);
    check("timeout_set", 32'(timeout), 32'd1);
    repeat (50) @(posedge sys_clk);
    @(negedge sys_clk);
    check("timeout_held", 32'(timeout), 32'd1);

    // Recovery edge: no capture, previous result retained.
    toggle_after(1, 1'b0, 26'd0, 1'b0);
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    check("timeout_clear", 32'(timeout), 32'd0);
    check("period_kept", 32'(period_cnt), 32'd96);
    check("range_kept", 32'(in_range), 32'd0);
    check("edge_cnt_11", 32'(edge_cnt), 32'd11);

    // Edge on the very last count beats the timeout.
    toggle_after(295, 1'b1, 26'd299, 1'b0);
    repeat (10) @(posedge sys_clk);
    @(negedge sys_clk);
    check("timeout_race", 32'(timeout), 32'd0);
    check("edge_cnt_12", 32'(edge_cnt), 32'd12);

    // sig_in high across reset release arms the FSM with a single edge.
    sys_rst = 1'b1;
    sig_in  = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_zero("reset_hi");
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    repeat (10) @(posedge sys_clk);
    @(negedge sys_clk);
    check("arm_edge_cnt", 32'(edge_cnt), 32'd1);
    check("arm_vld", 32'(period_vld), 32'd0);
    toggle_after(90, 1'b1, 26'd99, 1'b1);

    // Reset in the middle of a measurement.
    repeat (40) @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    sig_in = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_zero("reset_mid");
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;

    // 65536 edges, one per cycle: edge_cnt wraps back to zero.
    for (int i = 0; i < 65536; i++) begin
      @(posedge sys_clk);
      #1 sig_in = ~sig_in;
      if (i != 0) begin
        e.cnt = 26'd0;
        e.rng = 1'b0;
        sb.push_back(e);
      end
    end
    repeat (10) @(posedge sys_clk);
    @(negedge sys_clk);
    check("edge_cnt_wrap", 32'(edge_cnt), 32'd0);
    check("timeout_wrap", 32'(timeout), 32'd0);
    toggle_after(90, 1'b1, 26'd99, 1'b1);

    repeat (10) @(posedge sys_clk);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge sys_clk);
    @(negedge sys_clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
